// File: rtl/write_data_if.sv
`default_nettype none
// ============================================================================
//  Module      : write_data_if
//  Description : Pixel-pair stream in, frame-store write port and status out.
//                The master side is the upstream stage; the slave side is the
//                write_data block.
//  Revision    : 1.0  initial release
// ============================================================================
interface write_data_if #(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512
);
    localparam int ADDR_WIDTH = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT / 2);

    // Stream from the upstream stage
    logic                  vertical_Pulse;
    logic                  horizontal_Pulse;
    logic [7:0]            data_R_Even;
    logic [7:0]            data_G_Even;
    logic [7:0]            data_B_Even;
    logic [7:0]            data_R_Odd;
    logic [7:0]            data_G_Odd;
    logic [7:0]            data_B_Odd;

    // Frame-store write port and status
    logic                  wr_En;
    logic [ADDR_WIDTH-1:0] wr_Addr;
    logic [47:0]           wr_Data;
    logic                  done_Flag;
    logic                  row_Error;
    logic                  overflow_Error;

    modport master (
        output vertical_Pulse, horizontal_Pulse,
        output data_R_Even, data_G_Even, data_B_Even,
        output data_R_Odd, data_G_Odd, data_B_Odd,
        input  wr_En, wr_Addr, wr_Data, done_Flag, row_Error, overflow_Error
    );

    modport slave (
        input  vertical_Pulse, horizontal_Pulse,
        input  data_R_Even, data_G_Even, data_B_Even,
        input  data_R_Odd, data_G_Odd, data_B_Odd,
        output wr_En, wr_Addr, wr_Data, done_Flag, row_Error, overflow_Error
    );
endinterface
`default_nettype wire

// File: rtl/write_data.sv
`default_nettype none
// ============================================================================
//  Module      : write_data
//  Description : Packs even/odd RGB pixel pairs into 48-bit BGR words and
//                writes them bottom-up into a frame store. Flags frame
//                completion, short rows and pairs arriving outside a frame.
//  Revision    : 1.0  initial release
// ============================================================================
module write_data #(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512
) (
    input  wire          clk,
    input  wire          reset,
    write_data_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT / 2);
    localparam int COL_W      = (IMAGE_WIDTH / 2 > 1) ? $clog2(IMAGE_WIDTH / 2) : 1;
    localparam int ROW_W      = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [COL_W-1:0]      c_COL_LAST  = COL_W'(IMAGE_WIDTH / 2 - 1);
    localparam logic [ROW_W-1:0]      c_ROW_LAST  = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ROW_PAIRS = ADDR_WIDTH'(IMAGE_WIDTH / 2);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ROW = 2'd1,
        ST_IN_ROW   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                r_state,   w_state_nxt;
    logic [COL_W-1:0]      r_col,     w_col_nxt;
    logic [ROW_W-1:0]      r_row,     w_row_nxt;
    logic                  r_wr_en,   w_wr_en_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [47:0]           r_wr_data, w_wr_data_nxt;
    logic                  r_done,    w_done_nxt;
    logic                  r_row_err, w_row_err_nxt;
    logic                  r_ovf_err, w_ovf_err_nxt;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [47:0]           w_pair;

    // Bottom-up placement: first received row maps to the last memory row
    assign w_addr = (ADDR_WIDTH'(c_ROW_LAST) - ADDR_WIDTH'(r_row)) * c_ROW_PAIRS
                  + ADDR_WIDTH'(r_col);

    // BMP byte order, low byte first: B,G,R of even pixel then of odd pixel
    assign w_pair = {bus.data_R_Odd,  bus.data_G_Odd,  bus.data_B_Odd,
                     bus.data_R_Even, bus.data_G_Even, bus.data_B_Even};

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_row_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_done    <= w_done_nxt;
            r_row_err <= w_row_err_nxt;
            r_ovf_err <= w_ovf_err_nxt;
        end
    end

    // Next-state, counter and output decisions; frame start overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_done_nxt    = r_done;
        w_row_err_nxt = r_row_err;
        w_ovf_err_nxt = r_ovf_err;

        if (bus.vertical_Pulse) begin
            // Any pair presented together with the frame start is dropped
            w_state_nxt   = ST_WAIT_ROW;
            w_col_nxt     = '0;
            w_row_nxt     = '0;
            w_done_nxt    = 1'b0;
            w_row_err_nxt = 1'b0;
            w_ovf_err_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_ROW, ST_IN_ROW: begin
                    if (bus.horizontal_Pulse) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = w_addr;
                        w_wr_data_nxt = w_pair;
                        if (r_col == c_COL_LAST) begin
                            // Row complete; a width-2 image lands here from WAIT_ROW
                            w_col_nxt = '0;
                            if (r_row == c_ROW_LAST) begin
                                w_state_nxt = ST_DONE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_row_nxt   = r_row + ROW_W'(1);
                                w_state_nxt = ST_WAIT_ROW;
                            end
                        end else begin
                            w_col_nxt   = r_col + COL_W'(1);
                            w_state_nxt = ST_IN_ROW;
                        end
                    end else if (r_state == ST_IN_ROW) begin
                        // Burst ended mid-row: restart this row on the next burst
                        w_row_err_nxt = 1'b1;
                        w_col_nxt     = '0;
                        w_state_nxt   = ST_WAIT_ROW;
                    end
                end
                default: begin
                    // IDLE or DONE: a pair here is outside any frame
                    if (bus.horizontal_Pulse) begin
                        w_ovf_err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.wr_En          = r_wr_en;
    assign bus.wr_Addr        = r_wr_addr;
    assign bus.wr_Data        = r_wr_data;
    assign bus.done_Flag      = r_done;
    assign bus.row_Error      = r_row_err;
    assign bus.overflow_Error = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_write_data.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_data
//  Description : Bench for write_data. A small 4x2 instance and a default
//                768x512 instance share one stimulus stream and are compared
//                each cycle against a frame-level behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_write_data;
    localparam int SW = 4;
    localparam int SH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       v, h;
    logic [7:0] re, ge, be, ro, go, bo;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    write_data_if #(.IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH)) bus_s ();
    write_data_if bus_d ();

    assign bus_s.vertical_Pulse   = v;
    assign bus_s.horizontal_Pulse = h;
    assign bus_s.data_R_Even      = re;
    assign bus_s.data_G_Even      = ge;
    assign bus_s.data_B_Even      = be;
    assign bus_s.data_R_Odd       = ro;
    assign bus_s.data_G_Odd       = go;
    assign bus_s.data_B_Odd       = bo;
    assign bus_d.vertical_Pulse   = v;
    assign bus_d.horizontal_Pulse = h;
    assign bus_d.data_R_Even      = re;
    assign bus_d.data_G_Even      = ge;
    assign bus_d.data_B_Even      = be;
    assign bus_d.data_R_Odd       = ro;
    assign bus_d.data_G_Odd       = go;
    assign bus_d.data_B_Odd       = bo;

    write_data #(.IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    write_data dut_d (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_d.slave)
    );

    // Reference model, one slot per instance: frame progress as pair counts
    int          m_w[2], m_h[2];
    bit          m_active[2], m_done[2], m_rerr[2], m_ovf[2], m_we[2];
    int          m_col[2], m_row[2];
    logic [63:0] m_addr[2];
    logic [47:0] m_data[2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input int i);
        if (!reset) begin
            m_active[i] = 0; m_done[i] = 0; m_rerr[i] = 0; m_ovf[i] = 0; m_we[i] = 0;
            m_col[i] = 0; m_row[i] = 0; m_addr[i] = '0; m_data[i] = '0;
        end else if (v) begin
            m_active[i] = 1; m_done[i] = 0; m_rerr[i] = 0; m_ovf[i] = 0; m_we[i] = 0;
            m_col[i] = 0; m_row[i] = 0;
        end else if (h) begin
            if (!m_active[i]) begin
                m_ovf[i] = 1;
                m_we[i]  = 0;
            end else begin
                m_we[i]   = 1;
                m_addr[i] = 64'((m_h[i] - 1 - m_row[i]) * (m_w[i] / 2) + m_col[i]);
                m_data[i] = {ro, go, bo, re, ge, be};
                m_col[i]++;
                if (m_col[i] == m_w[i] / 2) begin
                    m_col[i] = 0;
                    m_row[i]++;
                    if (m_row[i] == m_h[i]) begin
                        m_active[i] = 0;
                        m_done[i]   = 1;
                    end
                end
            end
        end else begin
            m_we[i] = 0;
            if (m_active[i] && m_col[i] != 0) begin
                m_rerr[i] = 1;
                m_col[i]  = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_val("s.wr_En",   64'(bus_s.wr_En),          64'(m_we[0]));
        check_val("s.wr_Addr", 64'(bus_s.wr_Addr),        m_addr[0]);
        check_val("s.wr_Data", 64'(bus_s.wr_Data),        64'(m_data[0]));
        check_val("s.done",    64'(bus_s.done_Flag),      64'(m_done[0]));
        check_val("s.rowerr",  64'(bus_s.row_Error),      64'(m_rerr[0]));
        check_val("s.ovf",     64'(bus_s.overflow_Error), 64'(m_ovf[0]));
        check_val("d.wr_En",   64'(bus_d.wr_En),          64'(m_we[1]));
        check_val("d.wr_Addr", 64'(bus_d.wr_Addr),        m_addr[1]);
        check_val("d.wr_Data", 64'(bus_d.wr_Data),        64'(m_data[1]));
        check_val("d.done",    64'(bus_d.done_Flag),      64'(m_done[1]));
        check_val("d.rowerr",  64'(bus_d.row_Error),      64'(m_rerr[1]));
        check_val("d.ovf",     64'(bus_d.overflow_Error), 64'(m_ovf[1]));
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic step(input logic rst_n, input logic vp, input logic hp, input logic [47:0] pix);
        reset = rst_n;
        v     = vp;
        h     = hp;
        {ro, go, bo, re, ge, be} = pix;
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [47:0] rnd_pix();
        return {$urandom(), $urandom_range(65535, 0)};
    endfunction

    initial begin
        m_w[0] = SW;  m_h[0] = SH;
        m_w[1] = 768; m_h[1] = 512;

        // Reset and idle
        step(1'b0, 1'b0, 1'b0, 48'h0);
        step(1'b0, 1'b0, 1'b1, rnd_pix());
        check_val("rst.wr_En", 64'(bus_s.wr_En), 64'd0);
        step(1'b1, 1'b0, 1'b0, 48'h0);

        // Nominal 4x2 frame with packing check
        step(1'b1, 1'b1, 1'b0, 48'h0);
        step(1'b1, 1'b0, 1'b1, 48'h445566_112233);
        check_val("pack", 64'(bus_s.wr_Data), 64'h445566112233);
        check_val("addr0", 64'(bus_s.wr_Addr), 64'd2);
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        check_val("addr1", 64'(bus_s.wr_Addr), 64'd3);
        step(1'b1, 1'b0, 1'b0, 48'h0);
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        check_val("addr2", 64'(bus_s.wr_Addr), 64'd0);
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        check_val("addr3", 64'(bus_s.wr_Addr), 64'd1);
        check_val("done", 64'(bus_s.done_Flag), 64'd1);

        // Short row, then rewrite and complete
        step(1'b1, 1'b1, 1'b0, 48'h0);
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        step(1'b1, 1'b0, 1'b0, 48'h0);
        check_val("short.err", 64'(bus_s.row_Error), 64'd1);
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        check_val("short.re2", 64'(bus_s.wr_Addr), 64'd2);
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        check_val("short.done", 64'(bus_s.done_Flag), 64'd1);

        // Overflow after done, then restart clears flags
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        check_val("ovf.we", 64'(bus_s.wr_En), 64'd0);
        check_val("ovf.flag", 64'(bus_s.overflow_Error), 64'd1);
        step(1'b1, 1'b1, 1'b0, 48'h0);
        check_val("restart", 64'({bus_s.done_Flag, bus_s.row_Error, bus_s.overflow_Error}), 64'd0);

        // Simultaneous vertical and horizontal mid-row
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        step(1'b1, 1'b1, 1'b1, rnd_pix());
        check_val("simul.we", 64'(bus_s.wr_En), 64'd0);
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        check_val("simul.addr", 64'(bus_s.wr_Addr), 64'd2);

        // Reset mid-burst on the default-size instance
        step(1'b1, 1'b1, 1'b0, 48'h0);
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        check_val("dflt.addr", 64'(bus_d.wr_Addr), 64'd196225);
        step(1'b0, 1'b0, 1'b1, rnd_pix());
        check_val("midrst", 64'({bus_d.wr_En, bus_d.wr_Addr, bus_d.wr_Data}), 64'd0);
        step(1'b1, 1'b0, 1'b1, rnd_pix());
        check_val("midrst.ign", 64'(bus_d.wr_En), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(99, 0) != 0),
                 ($urandom_range(49, 0) == 0),
                 ($urandom_range(9, 0) < 8),
                 rnd_pix());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/write_data.md
# write_data

Downstream consumer of the pixel-pair stream produced by the image reader/threshold stage. Accepts one even/odd RGB pixel pair per cycle while `horizontal_Pulse` is high, packs each pair into a 48-bit BMP-ordered word, and issues it to a frame-store write port. Addresses are bottom-up, so the first row received lands in the last memory row. The block also flags frame completion and stream-format errors.

## Interface
- `IMAGE_WIDTH`, default 768: pixels per row; must be even.
- `IMAGE_HEIGHT`, default 512: rows per frame.
- `ADDR_WIDTH`, localparam = `$clog2(IMAGE_WIDTH*IMAGE_HEIGHT/2)`: 18 at the defaults.
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk`  in  1  sole clock; all logic on the rising edge.
  - `reset`  in  1  synchronous, active-low reset.
- Stream inputs from the upstream stage:
  - `vertical_Pulse`  in  1  frame start; high for one or more cycles.
  - `horizontal_Pulse`  in  1  pair valid this cycle.
  - `data_R_Even`, `data_G_Even`, `data_B_Even`  in  8 each  even-pixel RGB.
  - `data_R_Odd`, `data_G_Odd`, `data_B_Odd`  in  8 each  odd-pixel RGB.
- Frame-store write port and status:
  - `wr_En`  out  1  write strobe, one cycle per accepted pair.
  - `wr_Addr`  out  ADDR_WIDTH  pair address in the frame store.
  - `wr_Data`  out  48  packed pair.
  - `done_Flag`  out  1  frame fully written; sticky.
  - `row_Error`  out  1  sticky: a row ended short.
  - `overflow_Error`  out  1  sticky: a pair arrived outside a frame.

## Operation
- Counters:
  - `col`, range 0..IMAGE_WIDTH/2-1: counts pairs within the current row.
  - `row`, range 0..IMAGE_HEIGHT-1: counts completed rows.
- FSM states: IDLE, WAIT_ROW, IN_ROW, DONE. Reset state is IDLE.
- `vertical_Pulse` high in any state:
  - next state WAIT_ROW;
  - `col`, `row`, `done_Flag`, `row_Error`, `overflow_Error` all cleared;
  - any pair on the same cycle is discarded with no write. Vertical has priority.
- WAIT_ROW:
  - `horizontal_Pulse` high → accept pair at `col`=0, then `col`=1 and go to IN_ROW;
  - special case IMAGE_WIDTH=2: the row completes immediately, handled as in the next bullet.
- IN_ROW, `horizontal_Pulse` high → accept pair.
  - If `col`=IMAGE_WIDTH/2-1: set `col`←0 and `row`←row+1.
  - If that row was IMAGE_HEIGHT-1: go to DONE; otherwise go to WAIT_ROW.
- IN_ROW, `horizontal_Pulse` low with `col`≠0 (short row):
  - set `row_Error`;
  - `col`←0, `row` unchanged, so the row is rewritten by the next burst;
  - go to WAIT_ROW.
- IDLE or DONE, `horizontal_Pulse` high without `vertical_Pulse`: set `overflow_Error`; no write.
- Address: `wr_Addr` = (IMAGE_HEIGHT-1-row)*(IMAGE_WIDTH/2) + col, computed from pre-increment counter values.
- Packing, low byte first in BMP BGR order:
  - `wr_Data[7:0]`=B_Even, `[15:8]`=G_Even, `[23:16]`=R_Even;
  - `[31:24]`=B_Odd, `[39:32]`=G_Odd, `[47:40]`=R_Odd.
- Every accepted pair produces exactly one write. Discarded pairs produce none.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Latency: all outputs are registered.
  - A pair accepted at edge N appears with `wr_En`=1 during cycle N+1.
  - `wr_Addr` and `wr_Data` are valid only while `wr_En`=1; they hold their last value otherwise.
- `done_Flag` rises in the same cycle as the final frame's `wr_En`. It stays high until reset or the next `vertical_Pulse`.
- Throughput: one pair per cycle with no back-pressure. Back-to-back rows are allowed, i.e. `horizontal_Pulse` may stay high across a row boundary; the row wraps without a gap.
- `reset` low mid-frame: on the next edge, state and counters are cleared, outputs return to reset values, and any pending write is dropped (`wr_En`=0).

## Test plan
- Nominal frame, W=4 H=2: `vertical_Pulse`, then 2 bursts of 2 pairs → 4 writes with `wr_Addr` 2,3,0,1; `done_Flag`=1 with the 4th `wr_En`; no errors.
- Packing: pair R/G/B_Even=0x11/0x22/0x33, R/G/B_Odd=0x44/0x55/0x66 → `wr_Data`=0x445566112233.
- Short row: first burst of 1 pair only → `row_Error`=1. The next 2-pair burst rewrites addresses 2,3 and the frame still completes with `done_Flag`=1.
- Overflow and restart: an extra pair after DONE → no `wr_En`, `overflow_Error`=1. A following `vertical_Pulse` clears `done_Flag` and both errors.
- Simultaneous events: `vertical_Pulse` and `horizontal_Pulse` high together mid-row → no write and counters 0. The next pair writes the address for row 0, col 0 (=2 at W=4 H=2).
- Reset mid-burst at default size: `reset` low for 1 cycle while `horizontal_Pulse` is high → all outputs 0 next cycle and state IDLE; pairs are then ignored until `vertical_Pulse`.
